// File: rtl/fwd_operand_stage_if.sv
// Bus bundle for fwd_operand_stage: ID sources, EX/MEM/WB write ports, hold,
// and the registered ID/EX operand outputs. The stage uses the slave modport.
interface fwd_operand_stage_if #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int NUM_OPS     = 2,
    parameter int STALL_CNT_W = 16
);
    logic                        id_valid;
    logic [NUM_OPS*REG_AW-1:0]   id_src_addr;
    logic [NUM_OPS-1:0]          id_src_used;
    logic [NUM_OPS*DATA_W-1:0]   id_rf_data;
    logic                        ex_wr_en;
    logic                        ex_is_load;
    logic [REG_AW-1:0]           ex_dest;
    logic [DATA_W-1:0]           ex_data;
    logic                        mem_wr_en;
    logic [REG_AW-1:0]           mem_dest;
    logic [DATA_W-1:0]           mem_data;
    logic                        wb_wr_en;
    logic [REG_AW-1:0]           wb_dest;
    logic [DATA_W-1:0]           wb_data;
    logic                        hold;
    logic                        stall_out;
    logic                        op_valid;
    logic [NUM_OPS*DATA_W-1:0]   op_data;
    logic [NUM_OPS*3-1:0]        op_sel;
    logic [STALL_CNT_W-1:0]      stall_count;

    modport master (
        output id_valid, id_src_addr, id_src_used, id_rf_data,
        output ex_wr_en, ex_is_load, ex_dest, ex_data,
        output mem_wr_en, mem_dest, mem_data,
        output wb_wr_en, wb_dest, wb_data, hold,
        input  stall_out, op_valid, op_data, op_sel, stall_count
    );

    modport slave (
        input  id_valid, id_src_addr, id_src_used, id_rf_data,
        input  ex_wr_en, ex_is_load, ex_dest, ex_data,
        input  mem_wr_en, mem_dest, mem_data,
        input  wb_wr_en, wb_dest, wb_data, hold,
        output stall_out, op_valid, op_data, op_sel, stall_count
    );
endinterface

// File: rtl/fwd_operand_stage.sv
// ID/EX operand resolution: per-channel forwarding select, load-use stall, registered operands.
// Optional macro FWD_WB_HISTORY_EN adds a one-entry retired-write history (sel 4).
module fwd_operand_stage #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int NUM_OPS     = 2,
    parameter int STALL_CNT_W = 16
) (
    input logic                clk,
    input logic                rst_n,
    fwd_operand_stage_if.slave bus
);

    localparam logic [2:0] SEL_RF   = 3'd0;
    localparam logic [2:0] SEL_EX   = 3'd1;
    localparam logic [2:0] SEL_MEM  = 3'd2;
    localparam logic [2:0] SEL_WB   = 3'd3;
    localparam logic [2:0] SEL_HIST = 3'd4;

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

    function automatic logic stage_match(
        input logic              wr_en,
        input logic [REG_AW-1:0] dest,
        input logic [REG_AW-1:0] src
    );
        return wr_en && (dest != {REG_AW{1'b0}}) && (dest == src);
    endfunction

    logic                       stall_s;
    logic [NUM_OPS*DATA_W-1:0]  res_data_s;
    logic [NUM_OPS*3-1:0]       res_sel_s;

    logic                       op_valid_r;
    logic [NUM_OPS*DATA_W-1:0]  op_data_r;
    logic [NUM_OPS*3-1:0]       op_sel_r;
    logic [STALL_CNT_W-1:0]     stall_count_r;

`ifdef FWD_WB_HISTORY_EN
    logic                       hist_valid_r;
    logic [REG_AW-1:0]          hist_dest_r;
    logic [DATA_W-1:0]          hist_data_r;

    // Remember the most recent nonzero writeback; independent of hold and stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_valid_r <= 1'b0;
            hist_dest_r  <= {REG_AW{1'b0}};
            hist_data_r  <= {DATA_W{1'b0}};
        end else if (bus.wb_wr_en && (bus.wb_dest != {REG_AW{1'b0}})) begin
            hist_valid_r <= 1'b1;
            hist_dest_r  <= bus.wb_dest;
            hist_data_r  <= bus.wb_data;
        end else begin
            hist_valid_r <= hist_valid_r;
            hist_dest_r  <= hist_dest_r;
            hist_data_r  <= hist_data_r;
        end
    end
`endif

    // Per-channel operand resolution, youngest producer first.
    always_comb begin
        res_data_s = {(NUM_OPS*DATA_W){1'b0}};
        res_sel_s  = {(NUM_OPS*3){1'b0}};
        for (int i = 0; i < NUM_OPS; i++) begin
            if (bus.id_src_addr[i*REG_AW +: REG_AW] == {REG_AW{1'b0}}) begin
                res_data_s[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                res_sel_s[i*3 +: 3]            = SEL_RF;
            end else if (!bus.ex_is_load &&
                         stage_match(bus.ex_wr_en, bus.ex_dest, bus.id_src_addr[i*REG_AW +: REG_AW])) begin
                res_data_s[i*DATA_W +: DATA_W] = bus.ex_data;
                res_sel_s[i*3 +: 3]            = SEL_EX;
            end else if (stage_match(bus.mem_wr_en, bus.mem_dest, bus.id_src_addr[i*REG_AW +: REG_AW])) begin
                res_data_s[i*DATA_W +: DATA_W] = bus.mem_data;
                res_sel_s[i*3 +: 3]            = SEL_MEM;
            end else if (stage_match(bus.wb_wr_en, bus.wb_dest, bus.id_src_addr[i*REG_AW +: REG_AW])) begin
                res_data_s[i*DATA_W +: DATA_W] = bus.wb_data;
                res_sel_s[i*3 +: 3]            = SEL_WB;
`ifdef FWD_WB_HISTORY_EN
            end else if (stage_match(hist_valid_r, hist_dest_r, bus.id_src_addr[i*REG_AW +: REG_AW])) begin
                res_data_s[i*DATA_W +: DATA_W] = hist_data_r;
                res_sel_s[i*3 +: 3]            = SEL_HIST;
`endif
            end else begin
                res_data_s[i*DATA_W +: DATA_W] = bus.id_rf_data[i*DATA_W +: DATA_W];
                res_sel_s[i*3 +: 3]            = SEL_RF;
            end
        end
    end

    // Load-use detection: a used source waiting on a load still in EX.
    always_comb begin
        stall_s = 1'b0;
        for (int i = 0; i < NUM_OPS; i++) begin
            stall_s = stall_s | (bus.id_src_used[i] &
                      stage_match(bus.ex_wr_en, bus.ex_dest, bus.id_src_addr[i*REG_AW +: REG_AW]));
        end
        stall_s = stall_s & bus.id_valid & bus.ex_is_load;
    end

    // ID/EX pipeline register: hold freezes, a stall inserts a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid_r <= 1'b0;
            op_data_r  <= {(NUM_OPS*DATA_W){1'b0}};
            op_sel_r   <= {(NUM_OPS*3){1'b0}};
        end else if (bus.hold) begin
            op_valid_r <= op_valid_r;
            op_data_r  <= op_data_r;
            op_sel_r   <= op_sel_r;
        end else if (stall_s) begin
            op_valid_r <= 1'b0;
            op_data_r  <= res_data_s;
            op_sel_r   <= res_sel_s;
        end else begin
            op_valid_r <= bus.id_valid;
            op_data_r  <= res_data_s;
            op_sel_r   <= res_sel_s;
        end
    end

    // Saturating count of stall cycles that actually took effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_r <= {STALL_CNT_W{1'b0}};
        end else if (stall_s && !bus.hold && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign bus.stall_out   = stall_s;
    assign bus.op_valid    = op_valid_r;
    assign bus.op_data     = op_data_r;
    assign bus.op_sel      = op_sel_r;
    assign bus.stall_count = stall_count_r;

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Scoreboard bench for fwd_operand_stage: expectations queued at drive time, popped after the edge.
module tb_fwd_operand_stage;
    localparam int DATA_W      = 32;
    localparam int REG_AW      = 5;
    localparam int NUM_OPS     = 2;
    localparam int STALL_CNT_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fwd_operand_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_OPS(NUM_OPS),
                           .STALL_CNT_W(STALL_CNT_W)) bus ();

    fwd_operand_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_OPS(NUM_OPS),
                        .STALL_CNT_W(STALL_CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic [5:0]  s;
        logic        chk_d;
    } exp_t;

    exp_t        sb_q[$];
    string       tag_q[$];
    int          total = 0;
    int          bad   = 0;
    logic        v_last;
    logic [63:0] d_last;
    logic [5:0]  s_last;
    logic        chk_last;
    logic [15:0] cnt_model;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.id_valid    = 1'b1;
        bus.id_src_addr = '0;
        bus.id_src_used = 2'b11;
        bus.id_rf_data  = '0;
        bus.ex_wr_en    = 1'b0;
        bus.ex_is_load  = 1'b0;
        bus.ex_dest     = '0;
        bus.ex_data     = '0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_dest    = '0;
        bus.mem_data    = '0;
        bus.wb_wr_en    = 1'b0;
        bus.wb_dest     = '0;
        bus.wb_data     = '0;
        bus.hold        = 1'b0;
    endtask

    task automatic set_src(input logic [4:0] a0, input logic [31:0] rf0,
                           input logic [4:0] a1, input logic [31:0] rf1);
        bus.id_src_addr = {a1, a0};
        bus.id_rf_data  = {rf1, rf0};
    endtask

    // Called at a negedge with inputs set; checks stall_out, then the registered result.
    task automatic step(input string tag, input logic v, input logic [63:0] d,
                        input logic [5:0] s, input logic exp_stall);
        exp_t  e;
        string t;
        #1;
        check_val({tag, "_stall"}, 64'(bus.stall_out), 64'(exp_stall));
        if (bus.hold) e = '{v_last, d_last, s_last, chk_last};
        else if (exp_stall) e = '{1'b0, d, s, 1'b0};
        else e = '{v, d, s, 1'b1};
        sb_q.push_back(e);
        tag_q.push_back(tag);
        if (exp_stall && !bus.hold && cnt_model != 16'hFFFF) cnt_model++;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check_val({t, "_valid"}, 64'(bus.op_valid), 64'(e.v));
        if (e.chk_d) begin
            check_val({t, "_data"}, bus.op_data, e.d);
            check_val({t, "_sel"}, 64'(bus.op_sel), 64'(e.s));
        end
        check_val({t, "_cnt"}, 64'(bus.stall_count), 64'(cnt_model));
        v_last   = e.v;
        d_last   = e.d;
        s_last   = e.s;
        chk_last = e.chk_d;
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        cnt_model = 16'h0;
        v_last = 1'b0; d_last = '0; s_last = '0; chk_last = 1'b1;
        #12;
        check_val("rst_valid", 64'(bus.op_valid), 64'h0);
        check_val("rst_data", bus.op_data, 64'h0);
        check_val("rst_sel", 64'(bus.op_sel), 64'h0);
        check_val("rst_cnt", 64'(bus.stall_count), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        bus.ex_wr_en = 1'b1; bus.ex_dest = 5'd8; bus.ex_data = 32'h1111;
        set_src(5'd8, 32'h9999, 5'd2, 32'h2222);
        step("ex_fwd", 1'b1, {32'h2222, 32'h1111}, {3'd0, 3'd1}, 1'b0);

        bus.ex_dest = 5'd9; bus.ex_data = 32'hAAAA;
        bus.mem_wr_en = 1'b1; bus.mem_dest = 5'd9; bus.mem_data = 32'hBBBB;
        set_src(5'd0, 32'h5678, 5'd9, 32'h1234);
        step("ex_over_mem", 1'b1, {32'hAAAA, 32'h0}, {3'd1, 3'd0}, 1'b0);

        bus.ex_wr_en = 1'b0;
        step("mem_fwd", 1'b1, {32'hBBBB, 32'h0}, {3'd2, 3'd0}, 1'b0);

        clear_inputs();
        bus.wb_wr_en = 1'b1; bus.wb_dest = 5'd5; bus.wb_data = 32'h3333;
        set_src(5'd5, 32'h0, 5'd6, 32'h6666);
        step("wb_fwd", 1'b1, {32'h6666, 32'h3333}, {3'd0, 3'd3}, 1'b0);

        clear_inputs();
        bus.ex_wr_en = 1'b1; bus.ex_is_load = 1'b1; bus.ex_dest = 5'd4; bus.ex_data = 32'hEEEE;
        set_src(5'd4, 32'h0, 5'd7, 32'h7777);
        step("load_use", 1'b0, 64'h0, 6'h0, 1'b1);

        clear_inputs();
        bus.mem_wr_en = 1'b1; bus.mem_dest = 5'd4; bus.mem_data = 32'h4444;
        set_src(5'd4, 32'h0, 5'd7, 32'h7777);
        step("after_load", 1'b1, {32'h7777, 32'h4444}, {3'd0, 3'd2}, 1'b0);

        clear_inputs();
        bus.ex_wr_en = 1'b1; bus.ex_is_load = 1'b1; bus.ex_dest = 5'd4; bus.ex_data = 32'hEEEE;
        bus.id_src_used = 2'b10;
        set_src(5'd4, 32'h0404, 5'd7, 32'h7777);
        step("unused_no_stall", 1'b1, {32'h7777, 32'h0404}, {3'd0, 3'd0}, 1'b0);

        clear_inputs();
        bus.mem_wr_en = 1'b1; bus.mem_dest = 5'd0; bus.mem_data = 32'h5;
        bus.wb_wr_en = 1'b1; bus.wb_dest = 5'd0; bus.wb_data = 32'h5;
        set_src(5'd0, 32'hDEAD, 5'd0, 32'hBEEF);
        step("r0_zero", 1'b1, 64'h0, 6'h0, 1'b0);

        clear_inputs();
        bus.wb_wr_en = 1'b1; bus.wb_dest = 5'd3; bus.wb_data = 32'h77;
        set_src(5'd1, 32'h1, 5'd2, 32'h2);
        step("hist_wr", 1'b1, {32'h2, 32'h1}, 6'h0, 1'b0);

        clear_inputs();
        set_src(5'd3, 32'h0, 5'd5, 32'h55);
`ifdef FWD_WB_HISTORY_EN
        step("hist_rd", 1'b1, {32'h55, 32'h77}, {3'd0, 3'd4}, 1'b0);
`else
        step("hist_rd", 1'b1, {32'h55, 32'h0}, {3'd0, 3'd0}, 1'b0);
`endif

        clear_inputs();
        bus.ex_wr_en = 1'b1; bus.ex_dest = 5'd8; bus.ex_data = 32'h1111;
        set_src(5'd8, 32'h0, 5'd0, 32'h0);
        step("pre_hold", 1'b1, {32'h0, 32'h1111}, {3'd0, 3'd1}, 1'b0);

        bus.hold = 1'b1; bus.ex_is_load = 1'b1;
        step("hold_stall", 1'b0, 64'h0, 6'h0, 1'b1);

        // Asynchronous reset in the middle of a held stall.
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", 64'(bus.op_valid), 64'h0);
        check_val("mid_rst_data", bus.op_data, 64'h0);
        check_val("mid_rst_sel", 64'(bus.op_sel), 64'h0);
        check_val("mid_rst_cnt", 64'(bus.stall_count), 64'h0);
        check_val("mid_rst_stall", 64'(bus.stall_out), 64'h1);
        cnt_model = 16'h0;
        v_last = 1'b0; d_last = '0; s_last = '0; chk_last = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();

        bus.id_valid = 1'b0;
        bus.ex_wr_en = 1'b1; bus.ex_is_load = 1'b1; bus.ex_dest = 5'd8;
        set_src(5'd8, 32'h0808, 5'd0, 32'h0);
        step("idle_load", 1'b0, {32'h0, 32'h0808}, 6'h0, 1'b0);

        bus.id_valid = 1'b1;
        for (int k = 0; k < 65534; k++) begin
            @(posedge clk);
            if (cnt_model != 16'hFFFF) cnt_model++;
        end
        #1;
        check_val("cnt_near_max", 64'(bus.stall_count), 64'hFFFE);
        check_val("cnt_model_near", 64'(bus.stall_count), 64'(cnt_model));
        @(posedge clk);
        #1;
        check_val("cnt_at_max", 64'(bus.stall_count), 64'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        check_val("cnt_saturated", 64'(bus.stall_count), 64'hFFFF);
        check_val("sat_bubble", 64'(bus.op_valid), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fwd_operand_stage.md
# fwd_operand_stage

Parametrised operand-resolution stage for the MIPS-32 pipeline, sitting at the ID/EX boundary. It generalises the fixed 3-input ALU bypass mux into a multi-operand unit that derives its own forwarding selects from register addresses, detects load-use hazards and requests a one-cycle stall. It registers the resolved operands into the ID/EX pipeline register and keeps a saturating stall counter. Without the optional history entry, the register file is write-before-read.

## Interface
- DATA_W, 32, operand/result width
- REG_AW, 5, register address width
- NUM_OPS, 2, operand channels (rs, rt); channel i uses slice [i*W +: W] of each packed bus
- STALL_CNT_W, 16, stall counter width

- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  instruction present in ID
- id_src_addr  in  NUM_OPS*REG_AW  source register per channel
- id_src_used  in  NUM_OPS  channel actually reads its source
- id_rf_data  in  NUM_OPS*DATA_W  register-file read data
- ex_wr_en, ex_is_load  in  1 each  instruction in EX writes a register / is a load
- ex_dest  in  REG_AW;  ex_data  in  DATA_W  EX ALU result
- mem_wr_en  in  1;  mem_dest  in  REG_AW;  mem_data  in  DATA_W  EX/MEM result
- wb_wr_en  in  1;  wb_dest  in  REG_AW;  wb_data  in  DATA_W  MEM/WB writeback
- hold  in  1  downstream freeze of ID/EX
- stall_out  out  1  combinational; freeze PC and IF/ID, insert bubble
- op_valid  out  1  registered ID/EX valid
- op_data  out  NUM_OPS*DATA_W  registered resolved operands
- op_sel  out  NUM_OPS*3  registered source code: 0 RF, 1 EX, 2 MEM, 3 WB, 4 HIST
- stall_count  out  STALL_CNT_W  saturating stall-cycle count

## Operation
- Per channel, "src matches stage X" means X_wr_en && X_dest != 0 && X_dest == src addr.
- Priority per channel: EX (only if !ex_is_load) > MEM > WB > HIST > RF.
- Source address 0 resolves to data 0, sel 0, regardless of id_rf_data.
- Load-use: stall_out = id_valid && ex_is_load && any channel with id_src_used set that matches EX.
- stall_out depends only on current inputs. It is not gated by hold.
- Unused channels, with id_src_used = 0, still resolve and register data but never cause a stall.
- History entry (macro-dependent): on every clock edge, if wb_wr_en && wb_dest != 0, it captures {valid=1, wb_dest, wb_data}. This happens independently of hold and stall.

## Timing
- Reset (async, rst_n low): op_valid 0, op_data 0, op_sel 0, stall_count 0, history valid 0.
- Resolution is combinational. Output latency is 1 cycle: ID inputs at edge N appear on op_* after edge N.
- At each posedge, the ID/EX register (op_valid, op_data, op_sel) updates as follows:
  - hold = 1: it holds all values.
  - Else, stall_out = 1: op_valid <= 0 (bubble). op_data and op_sel load the resolved values, which are don't-care.
  - Else: op_valid <= id_valid and op_data/op_sel <= resolved values.
- stall_count increments when stall_out && !hold. It saturates at all-ones and never wraps.
- A load-use stall lasts exactly one cycle. Next cycle the load is in MEM and the operand is taken from mem_data.
- hold and stall together: the register holds and the counter does not increment. stall_out stays asserted.
- rst_n asserted mid-stall: outputs clear immediately. After release, stall_out follows inputs only.

## Configuration
- FWD_WB_HISTORY_EN defined: one-entry history register present. A HIST match supplies data for the register file's read-before-write case, i.e. a write retired one cycle earlier. This gives sel 4.
- Undefined: no history register and no sel 4. The resolved value falls back to id_rf_data after WB.

## Test plan
- ex_wr_en=1, ex_dest=8, ex_data=0x1111, id_src_addr ch0=8, id_valid=1 -> next cycle op_data ch0=0x1111, op_sel ch0=1, op_valid=1.
- ex and mem both write r9 (0xAAAA, 0xBBBB), ch1 reads r9 -> op_data ch1=0xAAAA (EX wins). With ex_wr_en=0 -> 0xBBBB, sel 2.
- ex_is_load=1, ex_dest=4, ch0 reads r4 with used=1 -> stall_out=1, next op_valid=0, stall_count=1. With used=0 -> no stall.
- Source r0 while mem writes r0 with 0x5 -> op_data 0, sel 0. stall_count preset near max via 65540 stall cycles -> stays 0xFFFF.
- With FWD_WB_HISTORY_EN: wb writes r3=0x77 at cycle N, ID reads r3 at N+1 with stale rf data 0x0 -> op_data 0x77, sel 4. Without the macro -> 0x0, sel 0.
- hold=1 during a stall, then rst_n low mid-operation -> op_* and stall_count freeze, then clear to 0 asynchronously.
